// File: rtl/gpio_pad_ctrl_if.sv
// Register-bus bundle for gpio_pad_ctrl: single-cycle req strobe with
// write/read qualifier, byte address and 32-bit data. Read data returns
// registered, one cycle after the request, flagged by rdata_valid.
interface gpio_pad_ctrl_if;
  logic        req;
  logic        wr;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;

  modport master (
    output req,
    output wr,
    output addr,
    output wdata,
    input  rdata,
    input  rdata_valid
  );

  modport slave (
    input  req,
    input  wr,
    input  addr,
    input  wdata,
    output rdata,
    output rdata_valid
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// GPIO bank placed between the CPU register bus and per-pin pad_inout
// wrappers. Drives pad_ena/to_pad from registers, samples from_pad through a
// 2-flop synchronizer, optional per-bit debouncer and an edge detector, and
// raises a level interrupt from the PENDING register.
// Optional feature macro: GPIO_DEBOUNCE_EN (defined -> per-bit debounce
// counters; undefined -> DIN follows the synchronizer every cycle).
module gpio_pad_ctrl #(
  parameter int unsigned NR_GPIOS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  gpio_pad_ctrl_if.slave      bus,
  output logic [NR_GPIOS-1:0] pad_ena,
  output logic [NR_GPIOS-1:0] to_pad,
  input  logic [NR_GPIOS-1:0] from_pad,
  output logic                irq
);

  typedef enum logic [2:0] {
    REG_DOUT    = 3'd0,
    REG_OE      = 3'd1,
    REG_DIN     = 3'd2,
    REG_RISE_IE = 3'd3,
    REG_FALL_IE = 3'd4,
    REG_PENDING = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_sel_e;

  reg_sel_e            sel;
  logic                wr_en;
  logic                rd_en;
  logic [NR_GPIOS-1:0] wdat;

  logic [NR_GPIOS-1:0] dout_q;
  logic [NR_GPIOS-1:0] oe_q;
  logic [NR_GPIOS-1:0] rise_ie_q;
  logic [NR_GPIOS-1:0] fall_ie_q;
  logic [NR_GPIOS-1:0] pending_q;

  logic [NR_GPIOS-1:0] sync1;
  logic [NR_GPIOS-1:0] sync2;
  logic [NR_GPIOS-1:0] din;
  logic [NR_GPIOS-1:0] din_d;

  logic [NR_GPIOS-1:0] pend_clr;
  logic [NR_GPIOS-1:0] edge_hit;
  logic [NR_GPIOS-1:0] pend_next;
  logic [NR_GPIOS-1:0] rd_bits;

  // Bus decode: register select and write/read qualifiers.
  always_comb begin
    sel   = reg_sel_e'(bus.addr[4:2]);
    wr_en = bus.req & bus.wr;
    rd_en = bus.req & ~bus.wr;
    wdat  = bus.wdata[NR_GPIOS-1:0];
  end

  // CPU-writable control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q    <= '0;
      oe_q      <= '0;
      rise_ie_q <= '0;
      fall_ie_q <= '0;
    end else if (wr_en) begin
      case (sel)
        REG_DOUT:    dout_q    <= wdat;
        REG_OE:      oe_q      <= wdat;
        REG_RISE_IE: rise_ie_q <= wdat;
        REG_FALL_IE: fall_ie_q <= wdat;
        default:     ;
      endcase
    end
  end

  assign pad_ena = oe_q;
  assign to_pad  = dout_q;

  // Two-flop synchronizer on the asynchronous pad inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= from_pad;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [NR_GPIOS];

  // Per-bit debounce: DIN takes sync2 only after DEBOUNCE_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      din <= '0;
      for (int unsigned i = 0; i < NR_GPIOS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NR_GPIOS; i++) begin
        if (sync2[i] == din[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          din[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  // Without debouncing, DIN is one more register stage behind sync2.
  always_ff @(posedge clk) begin
    if (reset) begin
      din <= '0;
    end else begin
      din <= sync2;
    end
  end
`endif

  // Delayed copy of DIN for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_d <= '0;
    end else begin
      din_d <= din;
    end
  end

  // Pending update: clear-by-write is applied first so a simultaneous set wins.
  always_comb begin
    pend_clr  = (wr_en && (sel == REG_PENDING)) ? wdat : '0;
    edge_hit  = (din & ~din_d & rise_ie_q) | (~din & din_d & fall_ie_q);
    pend_next = (pending_q & ~pend_clr) | edge_hit;
  end

  // Interrupt pending register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pend_next;
    end
  end

  assign irq = |pending_q;

  // Read-data multiplexer; reserved selects return zero.
  always_comb begin
    rd_bits = '0;
    case (sel)
      REG_DOUT:    rd_bits = dout_q;
      REG_OE:      rd_bits = oe_q;
      REG_DIN:     rd_bits = din;
      REG_RISE_IE: rd_bits = rise_ie_q;
      REG_FALL_IE: rd_bits = fall_ie_q;
      REG_PENDING: rd_bits = pending_q;
      default:     rd_bits = '0;
    endcase
  end

  // Registered read response; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
    end else begin
      bus.rdata_valid <= rd_en;
      if (rd_en) begin
        bus.rdata <= 32'(rd_bits);
      end
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl (NR_GPIOS=8, DEBOUNCE_CYCLES=4).
// A reference model tracks the register file and, per pin, decides DIN
// changes from a history of synchronized samples: DIN flips once the last
// window of samples all disagree with it and that window lies entirely after
// the previous flip or reset. The window is 4 with GPIO_DEBOUNCE_EN, else 1.
module tb_gpio_pad_ctrl;
  localparam int NR  = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int WIN = 4;
`else
  localparam int WIN = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] pad_ena;
  logic [NR-1:0] to_pad;
  logic [NR-1:0] from_pad;
  logic          irq;

  gpio_pad_ctrl_if bus ();

  gpio_pad_ctrl #(
    .NR_GPIOS        (NR),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pad_ena  (pad_ena),
    .to_pad   (to_pad),
    .from_pad (from_pad),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [NR-1:0] m_dout, m_oe, m_rie, m_fie, m_pend, m_din, m_din_d;
  logic [31:0]   m_rdata;
  logic          m_rvalid;
  logic [NR-1:0] pad_at [64];
  logic [NR-1:0] s_at   [64];
  int            cyc = 10;
  int            last_rst = 0;
  int            barrier [NR];

  function automatic logic [NR-1:0] m_read(input logic [2:0] r);
    case (r)
      3'd0: return m_dout;
      3'd1: return m_oe;
      3'd2: return m_din;
      3'd3: return m_rie;
      3'd4: return m_fie;
      3'd5: return m_pend;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [NR-1:0] s, nd, clr, hit;
    logic [2:0]    r;
    bit            flip;
    pad_at[6'(cyc)] = from_pad;
    if (reset) begin
      m_dout = '0; m_oe = '0; m_rie = '0; m_fie = '0; m_pend = '0;
      m_din = '0; m_din_d = '0; m_rdata = '0; m_rvalid = 1'b0;
      last_rst = cyc;
      for (int i = 0; i < NR; i++) barrier[i] = cyc;
      s_at[6'(cyc)] = '0;
    end else begin
      s = (cyc - 2 > last_rst) ? pad_at[6'(cyc - 2)] : '0;
      s_at[6'(cyc)] = s;
      nd = m_din;
      for (int i = 0; i < NR; i++) begin
        flip = (cyc - WIN >= barrier[i]);
        if (flip)
          for (int k = 0; k < WIN; k++)
            if (s_at[6'(cyc - k)][i] == m_din[i]) flip = 1'b0;
        if (flip) begin
          nd[i] = ~m_din[i];
          barrier[i] = cyc;
        end
      end
      r   = bus.addr[4:2];
      clr = (bus.req && bus.wr && r == 3'd5) ? bus.wdata[NR-1:0] : '0;
      hit = (m_din & ~m_din_d & m_rie) | (~m_din & m_din_d & m_fie);
      m_rvalid = bus.req && !bus.wr;
      if (bus.req && !bus.wr) m_rdata = 32'(m_read(r));
      if (bus.req && bus.wr) begin
        case (r)
          3'd0: m_dout = bus.wdata[NR-1:0];
          3'd1: m_oe   = bus.wdata[NR-1:0];
          3'd3: m_rie  = bus.wdata[NR-1:0];
          3'd4: m_fie  = bus.wdata[NR-1:0];
          default: ;
        endcase
      end
      m_pend  = (m_pend & ~clr) | hit;
      m_din_d = m_din;
      m_din   = nd;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("pad_ena", 32'(pad_ena), 32'(m_oe));
      check("to_pad", 32'(to_pad), 32'(m_dout));
      check("irq", 32'(irq), 32'(m_pend != '0));
      check("rdata_valid", 32'(bus.rdata_valid), 32'(m_rvalid));
      check("rdata", bus.rdata, m_rdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a);
    bus.req = 1'b1; bus.wr = 1'b0; bus.addr = a; bus.wdata = '0;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    from_pad = '0;
    repeat (3) @(posedge clk);
    #1 armed = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset state visible on every register
    for (int a = 0; a < 8; a++) bus_rd(5'(a * 4));
    idle(1);

    // Output registers drive the pads one cycle after the write
    bus_wr(5'h04, 32'h0000_000F);
    check("oe_direct", 32'(pad_ena), 32'h0F);
    bus_wr(5'h00, 32'hFFFF_FFA5);
    check("dout_direct", 32'(to_pad), 32'hA5);
    bus_rd(5'h00);
    check("dout_read", bus.rdata, 32'hA5);
    bus_rd(5'h18);
    check("rsvd_read", bus.rdata, 32'h0);
    idle(1);
    check("rvalid_pulse", 32'(bus.rdata_valid), 32'h0);

    // Held rise on pin0, 3-cycle glitch on pin1
    from_pad[0] = 1'b1;
    from_pad[1] = 1'b1;
    idle(3);
    from_pad[1] = 1'b0;
    for (int i = 0; i < 10; i++) bus_rd(5'h08);

    // Edge interrupts and W1C
    bus_wr(5'h0C, 32'h01);
    bus_wr(5'h10, 32'h02);
    from_pad[1] = 1'b1;
    idle(10);
    from_pad[0] = 1'b0;
    idle(10);
    from_pad[0] = 1'b1;
    from_pad[1] = 1'b0;
    idle(10);
    bus_rd(5'h14);
    check("pend_both", bus.rdata, 32'h03);
    bus_wr(5'h14, 32'h01);
    bus_rd(5'h14);
    check("pend_after_clr0", bus.rdata, 32'h02);
    bus_wr(5'h14, 32'h02);
    idle(1);
    check("irq_cleared", 32'(irq), 32'h0);

    // Clear pin0 every cycle while a new rise arrives: the set must win
    from_pad[0] = 1'b0;
    idle(10);
    from_pad[0] = 1'b1;
    for (int i = 0; i < 12; i++) bus_wr(5'h14, 32'h01);

    // Reset in the middle of a debounce count
    bus_wr(5'h04, 32'hFF);
    from_pad[2] = 1'b1;
    idle(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_pad_ena", 32'(pad_ena), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    bus_wr(5'h0C, 32'hFF);
    bus_wr(5'h10, 32'hFF);
    for (int i = 0; i < 10; i++) bus_rd(5'h08);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 399) == 0);
      bus.req   = ($urandom_range(0, 2) == 0);
      bus.wr    = $urandom_range(0, 1) == 1;
      bus.addr  = 5'($urandom);
      bus.wdata = $urandom;
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 9) == 0) from_pad[b] = ~from_pad[b];
      @(negedge clk);
    end
    reset = 1'b0;
    bus.req = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
